// File: rtl/clk_enable_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_enable_gen_pkg
// Shared types and helpers for the multi-channel clock-enable generator.
//   cfg_sel_e     : field selector for configuration writes
//   ch_cfg_t      : per-channel {div, high, phase} configuration
//   default_cfg() : reset configuration derived from the default divide ratio
//   eff_div()     : divide ratio as actually used (0 behaves as 1)
// CFG_W is the storage width of each field; the top-level DIV_W must not
// exceed it (narrower write data is zero-extended).
// -----------------------------------------------------------------------------
package clk_enable_gen_pkg;

   localparam int unsigned CFG_W = 16;

   typedef enum logic [1:0] {
      SEL_DIV   = 2'd0,
      SEL_HIGH  = 2'd1,
      SEL_PHASE = 2'd2,
      SEL_RSVD  = 2'd3
   } cfg_sel_e;

   typedef struct packed {
      logic [CFG_W-1:0] div;
      logic [CFG_W-1:0] high;
      logic [CFG_W-1:0] phase;
   } ch_cfg_t;

   function automatic ch_cfg_t default_cfg(input int unsigned def_div);
      ch_cfg_t c;
      c.div   = CFG_W'(def_div);
      c.high  = CFG_W'(def_div / 32'd2);
      c.phase = CFG_W'(0);
      return c;
   endfunction

   function automatic logic [CFG_W-1:0] eff_div(input logic [CFG_W-1:0] d);
      return (d == CFG_W'(0)) ? CFG_W'(1) : d;
   endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// -----------------------------------------------------------------------------
// clk_enable_gen_if
// Configuration bus of the clock-enable generator.
//   cfg_wr     : write shadow field this cycle
//   cfg_ch     : target channel
//   cfg_sel    : field selector (div / high / phase / reserved)
//   cfg_data   : write value
//   cfg_commit : copy shadows to active and restart all channels
//   cfg_err    : sticky configuration error flag (driven by the generator)
// master = configuration agent, slave = clk_enable_gen.
// -----------------------------------------------------------------------------
interface clk_enable_gen_if
   import clk_enable_gen_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DIV_W  = 16
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             cfg_wr;
   logic [CH_W-1:0]  cfg_ch;
   cfg_sel_e         cfg_sel;
   logic [DIV_W-1:0] cfg_data;
   logic             cfg_commit;
   logic             cfg_err;

   modport master (output cfg_wr, cfg_ch, cfg_sel, cfg_data, cfg_commit, input cfg_err);
   modport slave  (input cfg_wr, cfg_ch, cfg_sel, cfg_data, cfg_commit, output cfg_err);

endinterface

// File: rtl/clk_enable_ch.sv
// -----------------------------------------------------------------------------
// clk_enable_ch
// One channel of the clock-enable generator: active divide/high registers,
// the free-running channel counter, phase start-value with clamp, and the
// output decode.
//   refclk, rst : clock and asynchronous active-high reset
//   commit      : load new_cfg and restart the counter at its phase offset
//   new_cfg     : configuration to load (shadow including same-cycle write)
//   locked, en  : qualifiers for both outputs
//   ce, lvl     : enable pulse and square-wave level
//   clamp_err   : commit requested a phase >= divide ratio (clamped)
// -----------------------------------------------------------------------------
module clk_enable_ch
   import clk_enable_gen_pkg::*;
#(
   parameter int unsigned DEF_DIV = 4
)(
   input  logic    refclk,
   input  logic    rst,
   input  logic    commit,
   input  ch_cfg_t new_cfg,
   input  logic    locked,
   input  logic    en,
   output logic    ce,
   output logic    lvl,
   output logic    clamp_err
);

   localparam ch_cfg_t RST_CFG = default_cfg(DEF_DIV);

   // Phase is consumed at commit time into the counter start value, so only
   // div and high are kept as active state.
   logic [CFG_W-1:0] act_div_q, act_div_d;
   logic [CFG_W-1:0] act_high_q, act_high_d;
   logic [CFG_W-1:0] cnt_q, cnt_d;
   logic [CFG_W-1:0] act_div_s, new_div_s, start_phase_s;

   // Effective ratios and phase clamp for the incoming configuration
   always_comb begin
      act_div_s = eff_div(act_div_q);
      new_div_s = eff_div(new_cfg.div);
      if (new_cfg.phase >= new_div_s) begin
         start_phase_s = new_div_s - CFG_W'(1);
         clamp_err     = commit;
      end else begin
         start_phase_s = new_cfg.phase;
         clamp_err     = 1'b0;
      end
   end

   // Next-state: load on commit, otherwise count 0..div-1 and wrap.
   // Start value div-P makes the first cnt==0 land P cycles after the commit.
   always_comb begin
      act_div_d  = act_div_q;
      act_high_d = act_high_q;
      cnt_d      = cnt_q;
      if (commit) begin
         act_div_d  = new_cfg.div;
         act_high_d = new_cfg.high;
         if (start_phase_s == CFG_W'(0)) begin
            cnt_d = CFG_W'(0);
         end else begin
            cnt_d = new_div_s - start_phase_s;
         end
      end else if (cnt_q >= act_div_s - CFG_W'(1)) begin
         cnt_d = CFG_W'(0);
      end else begin
         cnt_d = cnt_q + CFG_W'(1);
      end
   end

   // Channel state registers
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         act_div_q  <= RST_CFG.div;
         act_high_q <= RST_CFG.high;
         cnt_q      <= CFG_W'(0);
      end else begin
         act_div_q  <= act_div_d;
         act_high_q <= act_high_d;
         cnt_q      <= cnt_d;
      end
   end

   // Decode straight from flops; high==0 never matches, high>=div always does
   assign ce  = locked && en && (cnt_q == CFG_W'(0));
   assign lvl = locked && en && (cnt_q < act_high_q);

endmodule

// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
// Multi-channel clock-enable generator. Each channel produces a one-cycle
// enable pulse per period and a square-wave level, with runtime-programmable
// divide ratio, high time and phase, written through shadow registers and
// applied together on commit. locked rises LOCK_CYCLES cycles after reset
// release or the last commit.
//   refclk      : sole clock, rising edge
//   rst         : asynchronous active-high reset
//   ch_en       : per-channel output gate (only with CLK_ENABLE_GEN_GATE_EN)
//   cfg_if      : configuration bus (slave modport), including cfg_err
//   ce_o, lvl_o : per-channel enable pulse and level
//   locked      : outputs valid
// Optional build macro: CLK_ENABLE_GEN_GATE_EN adds ch_en; gated channels
// keep counting so their phase survives re-enable.
// -----------------------------------------------------------------------------
module clk_enable_gen
   import clk_enable_gen_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DEF_DIV     = 4,
   parameter int unsigned LOCK_CYCLES = 8
)(
   input  logic              refclk,
   input  logic              rst,
`ifdef CLK_ENABLE_GEN_GATE_EN
   input  logic [NUM_CH-1:0] ch_en,
`endif
   clk_enable_gen_if.slave   cfg_if,
   output logic [NUM_CH-1:0] ce_o,
   output logic [NUM_CH-1:0] lvl_o,
   output logic              locked
);

   localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

   ch_cfg_t           shadow_q [NUM_CH];
   ch_cfg_t           shadow_d [NUM_CH];
   logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              locked_q, locked_d;
   logic              cfg_err_q, cfg_err_d;
   logic [NUM_CH-1:0] clamp_err_s;
   logic [NUM_CH-1:0] en_s;
   int unsigned       ch_idx_s;
   logic              ch_ok_s;
   logic              wr_err_s;

`ifdef CLK_ENABLE_GEN_GATE_EN
   assign en_s = ch_en;
`else
   assign en_s = {NUM_CH{1'b1}};
`endif

   // Shadow write decode; shadow_d doubles as the commit source so a write
   // in the commit cycle is included
   always_comb begin
      ch_idx_s = 32'(cfg_if.cfg_ch);
      ch_ok_s  = (ch_idx_s < NUM_CH);
      wr_err_s = cfg_if.cfg_wr && (!ch_ok_s || (cfg_if.cfg_sel == SEL_RSVD));
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         shadow_d[i] = shadow_q[i];
         if (cfg_if.cfg_wr && ch_ok_s && (ch_idx_s == i)) begin
            case (cfg_if.cfg_sel)
               SEL_DIV:   shadow_d[i].div   = CFG_W'(cfg_if.cfg_data);
               SEL_HIGH:  shadow_d[i].high  = CFG_W'(cfg_if.cfg_data);
               SEL_PHASE: shadow_d[i].phase = CFG_W'(cfg_if.cfg_data);
               default:   shadow_d[i]       = shadow_q[i];
            endcase
         end else begin
            shadow_d[i] = shadow_q[i];
         end
      end
   end

   // Lock counter: commit restarts it; locked goes high as it reaches zero
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      if (cfg_if.cfg_commit) begin
         lock_cnt_d = LCK_W'(LOCK_CYCLES);
         locked_d   = 1'b0;
      end else if (lock_cnt_q != LCK_W'(0)) begin
         lock_cnt_d = lock_cnt_q - LCK_W'(1);
         locked_d   = (lock_cnt_q == LCK_W'(1));
      end else begin
         lock_cnt_d = lock_cnt_q;
         locked_d   = 1'b1;
      end
   end

   // Sticky error: bad write target or clamped phase on any channel
   always_comb begin
      cfg_err_d = cfg_err_q | wr_err_s | (|clamp_err_s);
   end

   // Shadow, lock and error registers
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= default_cfg(DEF_DIV);
         end
         lock_cnt_q <= LCK_W'(LOCK_CYCLES);
         locked_q   <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_enable_ch #(
         .DEF_DIV   (DEF_DIV)
      ) u_ch (
         .refclk    (refclk),
         .rst       (rst),
         .commit    (cfg_if.cfg_commit),
         .new_cfg   (shadow_d[g]),
         .locked    (locked_q),
         .en        (en_s[g]),
         .ce        (ce_o[g]),
         .lvl       (lvl_o[g]),
         .clamp_err (clamp_err_s[g])
      );
   end

   assign locked         = locked_q;
   assign cfg_if.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
// Self-checking bench for clk_enable_gen. The reference model describes each
// channel by its divide ratio, high time and the absolute cycle at which its
// counter is zero; outputs are derived with modular arithmetic on the cycle
// number. Lock is the distance from the last commit / reset release.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;
   import clk_enable_gen_pkg::*;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 16;
   localparam int DEF_DIV     = 4;
   localparam int LOCK_CYCLES = 8;
   localparam int CH_W        = 2;
   localparam int VW          = 2 * NUM_CH + 2;

   logic              refclk;
   logic              rst;
   logic [NUM_CH-1:0] ce_o;
   logic [NUM_CH-1:0] lvl_o;
   logic [NUM_CH-1:0] en_v;
   logic              locked;

   clk_enable_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

   clk_enable_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEF_DIV     (DEF_DIV),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
`ifdef CLK_ENABLE_GEN_GATE_EN
      .ch_en  (en_v),
`endif
      .cfg_if (cfg_if),
      .ce_o   (ce_o),
      .lvl_o  (lvl_o),
      .locked (locked)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   int n_cmp;
   int n_fail;

   // Reference model state
   int cyc;
   int lock_evt;
   bit m_err;
   int m_div   [NUM_CH];
   int m_high  [NUM_CH];
   int m_org   [NUM_CH];
   int s_div   [NUM_CH];
   int s_high  [NUM_CH];
   int s_phase [NUM_CH];

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i]   = DEF_DIV;
         m_high[i]  = DEF_DIV / 2;
         m_org[i]   = 0;
         s_div[i]   = DEF_DIV;
         s_high[i]  = DEF_DIV / 2;
         s_phase[i] = 0;
      end
      cyc      = 0;
      lock_evt = 0;
      m_err    = 1'b0;
   endfunction

   // Expected {locked, cfg_err, lvl_o, ce_o} for the current cycle
   function automatic logic [VW-1:0] exp_vec();
      logic [NUM_CH-1:0] ce;
      logic [NUM_CH-1:0] lv;
      logic              lk;
      lk = ((cyc - lock_evt) >= LOCK_CYCLES);
      for (int i = 0; i < NUM_CH; i++) begin
         int d = eff(m_div[i]);
         int c = (((cyc - m_org[i]) % d) + d) % d;
         ce[i] = lk && en_v[i] && (c == 0);
         lv[i] = lk && en_v[i] && (c < m_high[i]);
      end
      return {lk, m_err, lv, ce};
   endfunction

   // Apply the currently driven config inputs to the model, take one clock
   // edge, and return at the following falling edge with pulses cleared
   task automatic clk_edge();
      int k = cyc + 1;
      if (cfg_if.cfg_wr) begin
         int ch = int'(cfg_if.cfg_ch);
         int v  = int'(cfg_if.cfg_data);
         case (cfg_if.cfg_sel)
            SEL_DIV:   s_div[ch]   = v;
            SEL_HIGH:  s_high[ch]  = v;
            SEL_PHASE: s_phase[ch] = v;
            default:   m_err       = 1'b1;
         endcase
      end
      if (cfg_if.cfg_commit) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int d = eff(s_div[i]);
            int p = s_phase[i];
            m_div[i]  = s_div[i];
            m_high[i] = s_high[i];
            if (p >= d) begin
               p     = d - 1;
               m_err = 1'b1;
            end
            m_org[i] = k + p;
         end
         lock_evt = k;
      end
      @(posedge refclk);
      cyc = k;
      @(negedge refclk);
      cfg_if.cfg_wr     = 1'b0;
      cfg_if.cfg_commit = 1'b0;
   endtask

   task automatic cfg_write(input int ch, input cfg_sel_e sel, input int data);
      cfg_if.cfg_wr   = 1'b1;
      cfg_if.cfg_ch   = CH_W'(ch);
      cfg_if.cfg_sel  = sel;
      cfg_if.cfg_data = DIV_W'(data);
      clk_edge();
   endtask

   task automatic do_commit();
      cfg_if.cfg_commit = 1'b1;
      clk_edge();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge refclk);
      @(negedge refclk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge refclk);
      n_cmp++;
      if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== VW'(0)) begin
         n_fail++;
         $display("FAIL reset_state got=%b exp=%b", {locked, cfg_if.cfg_err, lvl_o, ce_o}, VW'(0));
      end
      apply_reset();
      for (int c = 0; c < 24; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   task automatic test_rsvd_write();
      cfg_write(3, SEL_RSVD, 7);
      n_cmp++;
      if (cfg_if.cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL rsvd_err got=%b exp=1", cfg_if.cfg_err);
      end
      do_commit();
      for (int c = 0; c < 16; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL rsvd_nochange cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   task automatic test_phase();
      cfg_write(0, SEL_DIV, 10);
      cfg_write(0, SEL_PHASE, 0);
      cfg_write(1, SEL_DIV, 10);
      cfg_write(1, SEL_HIGH, 3);
      cfg_write(1, SEL_PHASE, 4);
      do_commit();
      n_cmp++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL phase_unlock got=%b exp=0", locked);
      end
      for (int c = 0; c < 36; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL phase cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   task automatic test_high_extremes();
      cfg_write(3, SEL_DIV, 10);
      cfg_write(3, SEL_HIGH, 0);
      do_commit();
      for (int c = 0; c < 26; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL high_zero cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
      cfg_write(3, SEL_HIGH, 20);
      do_commit();
      for (int c = 0; c < 26; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL high_full cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   task automatic test_back_to_back();
      int lo;
      cfg_if.cfg_wr     = 1'b1;
      cfg_if.cfg_ch     = CH_W'(0);
      cfg_if.cfg_sel    = SEL_DIV;
      cfg_if.cfg_data   = DIV_W'(6);
      cfg_if.cfg_commit = 1'b1;
      clk_edge();
      for (int c = 0; c < 2; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_gap cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
      do_commit();
      lo = 0;
      for (int c = 0; c < 20 && locked !== 1'b1; c++) begin
         lo++;
         clk_edge();
      end
      n_cmp++;
      if (lo !== LOCK_CYCLES) begin
         n_fail++;
         $display("FAIL b2b_lock_len got=%0d exp=%0d", lo, LOCK_CYCLES);
      end
      for (int c = 0; c < 20; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   task automatic test_clamp();
      apply_reset();
      cfg_write(2, SEL_DIV, 10);
      cfg_write(2, SEL_PHASE, 12);
      n_cmp++;
      if (cfg_if.cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL clamp_pre_err got=%b exp=0", cfg_if.cfg_err);
      end
      do_commit();
      for (int c = 0; c < 32; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL clamp cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   task automatic test_midreset();
      for (int c = 0; c < 5; c++) clk_edge();
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== VW'(0)) begin
         n_fail++;
         $display("FAIL midreset_async got=%b exp=%b", {locked, cfg_if.cfg_err, lvl_o, ce_o}, VW'(0));
      end
      @(posedge refclk);
      @(negedge refclk);
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 30; c++) begin
         if (c == 14) cfg_if.cfg_commit = 1'b1;
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL midreset cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

`ifdef CLK_ENABLE_GEN_GATE_EN
   task automatic test_gate();
      cfg_write(1, SEL_DIV, 5);
      cfg_write(1, SEL_HIGH, 2);
      cfg_write(1, SEL_PHASE, 3);
      do_commit();
      for (int c = 0; c < 10; c++) clk_edge();
      en_v[1] = 1'b0;
      for (int c = 0; c < 7; c++) begin
         clk_edge();
         n_cmp++;
         if ({ce_o[1], lvl_o[1]} !== 2'b00 || {locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL gate_off cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
      en_v[1] = 1'b1;
      for (int c = 0; c < 15; c++) begin
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL gate_on cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            cfg_if.cfg_wr   = 1'b1;
            cfg_if.cfg_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_if.cfg_sel  = cfg_sel_e'($urandom_range(0, 3));
            cfg_if.cfg_data = DIV_W'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 24) == 0) cfg_if.cfg_commit = 1'b1;
         clk_edge();
         n_cmp++;
         if ({locked, cfg_if.cfg_err, lvl_o, ce_o} !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {locked, cfg_if.cfg_err, lvl_o, ce_o}, exp_vec());
         end
      end
   endtask

   initial begin
      n_cmp             = 0;
      n_fail            = 0;
      en_v              = {NUM_CH{1'b1}};
      rst               = 1'b1;
      cfg_if.cfg_wr     = 1'b0;
      cfg_if.cfg_ch     = CH_W'(0);
      cfg_if.cfg_sel    = SEL_DIV;
      cfg_if.cfg_data   = DIV_W'(0);
      cfg_if.cfg_commit = 1'b0;
      model_reset();

      test_reset();
      test_rsvd_write();
      apply_reset();
      test_phase();
      test_high_extremes();
      test_back_to_back();
      test_clamp();
      test_midreset();
`ifdef CLK_ENABLE_GEN_GATE_EN
      test_gate();
`endif
      test_random();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
